// File: rtl/alt_dfe_pkg.sv
// rtl/alt_dfe_pkg.sv - shared register map, CTRL bit positions and FSM encodings
//
// Used by both the AVMM slave and the internal-register master stage so that
// both ends agree on offsets, CTRL layout and the control-FSM encoding.
package alt_dfe_pkg;

  // Slave word offsets
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_CHADDR = 2'd1;
  localparam logic [1:0] REG_WDADDR = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  // CTRL/STATUS bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_RWN     = 1;
  localparam int CTRL_BUSY    = 8;
  localparam int CTRL_ERROR   = 9;
  localparam int CTRL_TIMEOUT = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRIGGER   = 2'd1,
    ST_WAIT_DONE = 2'd2
  } dfe_state_e;

endpackage

// File: rtl/alt_dfe_avmm_slave.sv
// rtl/alt_dfe_avmm_slave.sv - AVMM slave that launches internal-register accesses
//
// Ports:
//   i_avmm_clk, i_resetn            clock, synchronous active-low reset
//   i_avmm_saddress/sread/swrite    slave word address and strobes
//   i_avmm_swritedata               slave write data
//   o_avmm_sreaddata                registered read data (valid in 2nd read cycle)
//   o_avmm_swaitrequest             high in the first cycle of every read
//   o_ir_trigger                    one-cycle request pulse to the master stage
//   o_ir_chaddress/wdaddress/
//   o_ir_writedata/o_ir_rwn         request fields, held for the whole operation
//   i_ir_done, i_ir_readdata        completion pulse and read result
module alt_dfe_avmm_slave
  import alt_dfe_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  i_avmm_clk,
  input  logic                  i_resetn,
  input  logic [1:0]            i_avmm_saddress,
  input  logic                  i_avmm_sread,
  input  logic                  i_avmm_swrite,
  input  logic [DATA_WIDTH-1:0] i_avmm_swritedata,
  output logic [DATA_WIDTH-1:0] o_avmm_sreaddata,
  output logic                  o_avmm_swaitrequest,
  output logic                  o_ir_trigger,
  output logic [DATA_WIDTH-1:0] o_ir_chaddress,
  output logic [DATA_WIDTH-1:0] o_ir_wdaddress,
  output logic [DATA_WIDTH-1:0] o_ir_writedata,
  output logic                  o_ir_rwn,
  input  logic                  i_ir_done,
  input  logic [DATA_WIDTH-1:0] i_ir_readdata
);

  // Counter only needs to reach TIMEOUT_CYCLES-1 before the FSM bails out.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] CH_LIMIT = DATA_WIDTH'(NUM_CHANNELS);

  dfe_state_e            state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] chaddr;
  logic [DATA_WIDTH-1:0] wdaddr;
  logic [DATA_WIDTH-1:0] data;
  logic                  rwn;
  logic                  error;
  logic                  timeout;
  logic                  rd_phase;

  logic                  busy;
  logic                  wr_ctrl;
  logic                  start_req;
  logic                  start_ok;
  logic                  start_bad;
  logic                  busy_wr;
  logic                  done_hit;
  logic                  timeout_hit;
  logic                  err_set;
  logic [DATA_WIDTH-1:0] ctrl_rd;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign busy        = (state != ST_IDLE);
  assign wr_ctrl     = i_avmm_swrite && (i_avmm_saddress == REG_CTRL);
  assign start_req   = wr_ctrl && i_avmm_swritedata[CTRL_START];
  assign start_ok    = start_req && !busy && (chaddr < CH_LIMIT);
  assign start_bad   = start_req && !busy && (chaddr >= CH_LIMIT);
  // While busy only a pure W1C CTRL write is legal; anything else is flagged.
  assign busy_wr     = busy && i_avmm_swrite &&
                       ((i_avmm_saddress != REG_CTRL) || i_avmm_swritedata[CTRL_START]);
  assign done_hit    = (state == ST_WAIT_DONE) && i_ir_done;
  assign timeout_hit = (state == ST_WAIT_DONE) && !i_ir_done && (cnt == CNT_LAST);
  assign err_set     = start_bad || busy_wr || timeout_hit;

  // One stall cycle per read; rd_phase marks the cycle the data is presented.
  assign o_avmm_swaitrequest = i_avmm_sread && !rd_phase;

  // Control FSM and request outputs
  always_ff @(posedge i_avmm_clk) begin
    if (!i_resetn) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      o_ir_trigger   <= 1'b0;
      o_ir_chaddress <= '0;
      o_ir_wdaddress <= '0;
      o_ir_writedata <= '0;
      o_ir_rwn       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state          <= ST_TRIGGER;
            cnt            <= '0;
            o_ir_trigger   <= 1'b1;
            o_ir_chaddress <= chaddr;
            o_ir_wdaddress <= wdaddr;
            o_ir_writedata <= data;
            o_ir_rwn       <= i_avmm_swritedata[CTRL_RWN];
          end
        end
        ST_TRIGGER: begin
          state        <= ST_WAIT_DONE;
          o_ir_trigger <= 1'b0;
        end
        ST_WAIT_DONE: begin
          if (i_ir_done || timeout_hit) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          o_ir_trigger <= 1'b0;
        end
      endcase
    end
  end

  // Host-visible registers
  always_ff @(posedge i_avmm_clk) begin
    if (!i_resetn) begin
      chaddr  <= '0;
      wdaddr  <= '0;
      data    <= '0;
      rwn     <= 1'b0;
      error   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (i_avmm_swrite && !busy) begin
        case (i_avmm_saddress)
          REG_CHADDR: chaddr <= i_avmm_swritedata;
          REG_WDADDR: wdaddr <= i_avmm_swritedata;
          REG_DATA:   data   <= i_avmm_swritedata;
          default:    rwn    <= i_avmm_swritedata[CTRL_RWN];
        endcase
      end
      if (done_hit && o_ir_rwn) begin
        data <= i_ir_readdata;
      end
      // Hardware set takes priority over a same-cycle W1C clear.
      error   <= err_set ||
                 (error && !(wr_ctrl && i_avmm_swritedata[CTRL_ERROR]));
      timeout <= timeout_hit ||
                 (timeout && !(wr_ctrl && i_avmm_swritedata[CTRL_TIMEOUT]));
    end
  end

  always_comb begin
    ctrl_rd               = '0;
    ctrl_rd[CTRL_RWN]     = rwn;
    ctrl_rd[CTRL_BUSY]    = busy;
    ctrl_rd[CTRL_ERROR]   = error;
    ctrl_rd[CTRL_TIMEOUT] = timeout;
  end

  always_comb begin
    case (i_avmm_saddress)
      REG_CHADDR: rd_mux = chaddr;
      REG_WDADDR: rd_mux = wdaddr;
      REG_DATA:   rd_mux = data;
      default:    rd_mux = ctrl_rd;
    endcase
  end

  // Read data is captured at the end of the stall cycle.
  always_ff @(posedge i_avmm_clk) begin
    if (!i_resetn) begin
      rd_phase         <= 1'b0;
      o_avmm_sreaddata <= '0;
    end else begin
      rd_phase <= i_avmm_sread && !rd_phase;
      if (o_avmm_swaitrequest) begin
        o_avmm_sreaddata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_alt_dfe_avmm_slave.sv
// tb/tb_alt_dfe_avmm_slave.sv - randomized and directed bench with reference model
module tb_alt_dfe_avmm_slave;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int TO  = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [1:0]    saddr;
  logic          sread;
  logic          swrite;
  logic [DW-1:0] wdata;
  logic [DW-1:0] readdata;
  logic          waitreq;
  logic          trig;
  logic [DW-1:0] chaddress;
  logic [DW-1:0] wdaddress;
  logic [DW-1:0] writedata;
  logic          rwn_o;
  logic          done;
  logic [DW-1:0] ir_rdata;

  alt_dfe_avmm_slave #(
    .NUM_CHANNELS  (NCH),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_avmm_clk         (clk),
    .i_resetn           (resetn),
    .i_avmm_saddress    (saddr),
    .i_avmm_sread       (sread),
    .i_avmm_swrite      (swrite),
    .i_avmm_swritedata  (wdata),
    .o_avmm_sreaddata   (readdata),
    .o_avmm_swaitrequest(waitreq),
    .o_ir_trigger       (trig),
    .o_ir_chaddress     (chaddress),
    .o_ir_wdaddress     (wdaddress),
    .o_ir_writedata     (writedata),
    .o_ir_rwn           (rwn_o),
    .i_ir_done          (done),
    .i_ir_readdata      (ir_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int trig_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers plus one outstanding operation tracked by age
  // (age 0 = trigger cycle, ages 1..TO = waiting for done).
  logic [15:0] m_chaddr, m_wdaddr, m_data, m_rdata;
  logic [15:0] op_ch, op_wd, op_wdata;
  logic        m_rwn, m_err, m_to, m_rd_phase, op_active, op_rwn;
  logic        m_valid = 1'b0;
  int          op_age;

  function automatic logic [15:0] model_read(input logic [1:0] a);
    logic [15:0] v;
    case (a)
      2'd1:    v = m_chaddr;
      2'd2:    v = m_wdaddr;
      2'd3:    v = m_data;
      default: begin
        v     = '0;
        v[1]  = m_rwn;
        v[8]  = op_active;
        v[9]  = m_err;
        v[10] = m_to;
      end
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic busy_now, hw_err, hw_to, clr_err, clr_to, start_now;
    busy_now  = op_active;
    hw_err    = 1'b0;
    hw_to     = 1'b0;
    clr_err   = 1'b0;
    clr_to    = 1'b0;
    start_now = 1'b0;
    if (!resetn) begin
      m_chaddr = '0; m_wdaddr = '0; m_data = '0; m_rdata = '0;
      op_ch = '0; op_wd = '0; op_wdata = '0; op_rwn = 1'b0;
      m_rwn = 1'b0; m_err = 1'b0; m_to = 1'b0; m_rd_phase = 1'b0;
      op_active = 1'b0; op_age = 0; m_valid = 1'b1;
      return;
    end
    if (sread && !m_rd_phase) m_rdata = model_read(saddr);
    m_rd_phase = sread && !m_rd_phase;
    if (swrite) begin
      if (saddr == 2'd0) begin
        clr_err = wdata[9];
        clr_to  = wdata[10];
        if (busy_now) begin
          hw_err = wdata[0];
        end else begin
          m_rwn = wdata[1];
          if (wdata[0]) begin
            if (m_chaddr < 16'(NCH)) start_now = 1'b1;
            else hw_err = 1'b1;
          end
        end
      end else if (busy_now) begin
        hw_err = 1'b1;
      end else begin
        case (saddr)
          2'd1:    m_chaddr = wdata;
          2'd2:    m_wdaddr = wdata;
          default: m_data   = wdata;
        endcase
      end
    end
    if (busy_now) begin
      if (op_age >= 1 && done) begin
        if (op_rwn) m_data = ir_rdata;
        op_active = 1'b0;
      end else if (op_age == TO) begin
        op_active = 1'b0;
        hw_err    = 1'b1;
        hw_to     = 1'b1;
      end else begin
        op_age++;
      end
    end
    if (start_now) begin
      op_active = 1'b1;
      op_age    = 0;
      op_ch     = m_chaddr;
      op_wd     = m_wdaddr;
      op_wdata  = m_data;
      op_rwn    = wdata[1];
    end
    m_err = hw_err | (m_err & !clr_err);
    m_to  = hw_to  | (m_to  & !clr_to);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare, away from the active edge
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("waitrequest", 32'(waitreq), 32'(sread && !m_rd_phase));
      if (sread && m_rd_phase) chk("readdata", 32'(readdata), 32'(m_rdata));
      chk("trigger", 32'(trig), 32'(op_active && op_age == 0));
      chk("ir_chaddress", 32'(chaddress), 32'(op_ch));
      chk("ir_wdaddress", 32'(wdaddress), 32'(op_wd));
      chk("ir_writedata", 32'(writedata), 32'(op_wdata));
      chk("ir_rwn", 32'(rwn_o), 32'(op_rwn));
      if (trig) trig_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    saddr  = a;
    wdata  = d;
    swrite = 1'b1;
    cyc();
    swrite = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    saddr = a;
    sread = 1'b1;
    cyc();
    cyc();
    v     = readdata;
    sread = 1'b0;
  endtask

  task automatic pulse_done(input logic [15:0] d);
    done     = 1'b1;
    ir_rdata = d;
    cyc();
    done     = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int          tc;
    int          act;
    resetn = 1'b0; sread = 1'b0; swrite = 1'b0; done = 1'b0;
    saddr = '0; wdata = '0; ir_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    for (int a = 0; a < 4; a++) begin
      logic [1:0] ad;
      ad = a[1:0];
      rd(ad, v);
      chk($sformatf("reset_reg%0d", a), 32'(v), 32'h0);
    end

    // Read operation on channel 1
    tc = trig_cnt;
    wr(2'd1, 16'h0001);
    wr(2'd2, 16'h0002);
    wr(2'd0, 16'h0003);
    chk("rd_trigger_high", 32'(trig), 32'h1);
    chk("rd_rwn", 32'(rwn_o), 32'h1);
    chk("rd_chaddr", 32'(chaddress), 32'h1);
    chk("rd_wdaddr", 32'(wdaddress), 32'h2);
    rd(2'd0, v);
    chk("rd_ctrl_busy", 32'(v), 32'h0102);
    cyc();
    cyc();
    pulse_done(16'h002A);
    rd(2'd0, v);
    chk("rd_ctrl_idle", 32'(v), 32'h0002);
    rd(2'd3, v);
    chk("rd_data_captured", 32'(v), 32'h002A);
    chk("rd_single_pulse", 32'(trig_cnt - tc), 32'h1);

    // Write operation, with an illegal DATA write while busy
    wr(2'd3, 16'h0005);
    wr(2'd0, 16'h0001);
    chk("wr_writedata", 32'(writedata), 32'h0005);
    chk("wr_rwn", 32'(rwn_o), 32'h0);
    wr(2'd3, 16'h1234);
    chk("busy_wr_writedata", 32'(writedata), 32'h0005);
    rd(2'd0, v);
    chk("busy_wr_ctrl", 32'(v), 32'h0300);
    cyc();
    chk("wr_writedata_held", 32'(writedata), 32'h0005);
    pulse_done(16'hFFFF);
    rd(2'd3, v);
    chk("wr_data_kept", 32'(v), 32'h0005);
    rd(2'd0, v);
    chk("wr_ctrl_err", 32'(v), 32'h0200);
    wr(2'd0, 16'h0200);
    rd(2'd0, v);
    chk("w1c_err", 32'(v), 32'h0000);

    // Out-of-range channel
    tc = trig_cnt;
    wr(2'd1, 16'h0004);
    wr(2'd0, 16'h0001);
    chk("badch_no_trigger", 32'(trig), 32'h0);
    rd(2'd0, v);
    chk("badch_ctrl", 32'(v), 32'h0200);
    chk("badch_pulses", 32'(trig_cnt - tc), 32'h0);
    wr(2'd0, 16'h0200);

    // Timeout
    wr(2'd1, 16'h0000);
    wr(2'd0, 16'h0001);
    repeat (TO + 3) cyc();
    rd(2'd0, v);
    chk("timeout_ctrl", 32'(v), 32'h0600);
    wr(2'd0, 16'h0600);
    rd(2'd0, v);
    chk("timeout_clear", 32'(v), 32'h0000);

    // Reset while waiting for done
    tc = trig_cnt;
    wr(2'd1, 16'h0002);
    wr(2'd3, 16'h0007);
    wr(2'd0, 16'h0003);
    repeat (3) cyc();
    resetn = 1'b0;
    cyc();
    chk("rst_trigger", 32'(trig), 32'h0);
    chk("rst_chaddr", 32'(chaddress), 32'h0);
    chk("rst_wdaddr", 32'(wdaddress), 32'h0);
    chk("rst_writedata", 32'(writedata), 32'h0);
    chk("rst_rwn", 32'(rwn_o), 32'h0);
    chk("rst_readdata", 32'(readdata), 32'h0);
    chk("rst_waitreq", 32'(waitreq), 32'h0);
    resetn = 1'b1;
    cyc();
    pulse_done(16'hBEEF);
    rd(2'd3, v);
    chk("rst_data", 32'(v), 32'h0);
    rd(2'd0, v);
    chk("rst_ctrl", 32'(v), 32'h0);
    chk("rst_pulses", 32'(trig_cnt - tc), 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 700; i++) begin
      logic [15:0] d;
      ir_rdata = 16'($urandom);
      act = $urandom_range(0, 9);
      if ($urandom_range(0, 299) == 0) begin
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
      end else if (act <= 3) begin
        saddr = 2'($urandom_range(0, 3));
        if (saddr == 2'd1) begin
          d = 16'($urandom_range(0, 5));
        end else if (saddr == 2'd0) begin
          d     = 16'($urandom) & 16'hF8FC;
          d[0]  = ($urandom_range(0, 2) == 0);
          d[1]  = 1'($urandom);
          d[9]  = ($urandom_range(0, 3) == 0);
          d[10] = ($urandom_range(0, 3) == 0);
        end else begin
          d = 16'($urandom);
        end
        wr(saddr, d);
      end else if (act <= 6) begin
        rd(2'($urandom_range(0, 3)), v);
      end else if (act == 7) begin
        pulse_done(16'($urandom));
      end else begin
        cyc();
      end
    end

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alt_dfe_avmm_slave.md
ALT_DFE_AVMM_SLAVE -- requirements
Module: alt_dfe_avmm_slave

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of valid channel addresses (0..NUM_CHANNELS-1).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of slave data and of all internal-register-bus fields.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1023, maximum cycles to wait for i_ir_done.
REQ-004 SHALL have port i_avmm_clk, input, 1, clock; all logic rises on it.
REQ-005 SHALL have port i_resetn, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port i_avmm_saddress, input, 2, slave word address.
REQ-007 SHALL have ports i_avmm_sread and i_avmm_swrite, input, 1 each, slave read and write strobes.
REQ-008 SHALL have port i_avmm_swritedata, input, DATA_WIDTH, slave write data.
REQ-009 SHALL have ports o_avmm_sreaddata (DATA_WIDTH) and o_avmm_swaitrequest (1), output, read data and slave stall.
REQ-010 SHALL have ports o_ir_trigger (1), o_ir_chaddress, o_ir_wdaddress, o_ir_writedata (DATA_WIDTH each) and o_ir_rwn (1), output, internal-register request to the master stage.
REQ-011 SHALL have ports i_ir_done (1) and i_ir_readdata (DATA_WIDTH), input, completion pulse and read result from the master stage.

Function
REQ-012 Register map SHALL be: 0 = CTRL/STATUS, 1 = CHADDR, 2 = WDADDR, 3 = DATA.
REQ-013 CTRL bits SHALL be: [0] start (write-only, reads 0), [1] rwn (R/W), [8] busy (RO), [9] error (W1C), [10] timeout (W1C); all others read 0.
REQ-014 Writes SHALL complete with zero wait states; reads SHALL assert o_avmm_swaitrequest in the first cycle of i_avmm_sread and present registered data with waitrequest low in the second.
REQ-015 Control FSM SHALL have states IDLE, TRIGGER and WAIT_DONE.
REQ-016 IDLE -> TRIGGER on a CTRL write with start=1 when CHADDR < NUM_CHANNELS; rwn SHALL be updated from the same write.
REQ-017 A start with CHADDR >= NUM_CHANNELS SHALL set error, stay in IDLE and never pulse o_ir_trigger.
REQ-018 TRIGGER SHALL drive o_ir_trigger high for exactly one cycle, then go to WAIT_DONE.
REQ-019 o_ir_chaddress, o_ir_wdaddress, o_ir_writedata and o_ir_rwn SHALL be registered copies, held stable from TRIGGER until return to IDLE.
REQ-020 busy SHALL read 1 in TRIGGER and WAIT_DONE.
REQ-021 WAIT_DONE -> IDLE on i_ir_done; if rwn=1, DATA SHALL capture i_ir_readdata in that same cycle.
REQ-022 A counter SHALL clear on entry to TRIGGER and increment in WAIT_DONE; on reaching TIMEOUT_CYCLES without i_ir_done the FSM SHALL go to IDLE and set timeout and error.
REQ-023 While busy, writes to CHADDR, WDADDR, DATA or CTRL start SHALL be ignored and SHALL set error; W1C writes to CTRL SHALL still apply.
REQ-024 i_ir_done in IDLE or TRIGGER SHALL be ignored.
REQ-025 A W1C clear and a hardware set of the same bit in one cycle SHALL leave the bit set.

Reset
REQ-026 On i_resetn=0 at a clock edge: FSM SHALL go to IDLE, counter SHALL clear, and all registers, error/timeout bits and every output SHALL go to 0, except o_avmm_swaitrequest, which SHALL follow REQ-014.
REQ-027 Reset during WAIT_DONE SHALL abandon the operation without pulsing o_ir_trigger again.

Structure
REQ-028 Register offsets, CTRL bit positions and FSM state encodings SHALL live in the shared package alt_dfe_pkg, where the master stage also uses them.
REQ-029 The block SHALL be one module with no sub-modules.

Verification
REQ-030 Bench SHALL cover: CHADDR=1, WDADDR=2, CTRL=0x3 -> single trigger pulse with rwn=1; i_ir_done with readdata 0x002A after 5 cycles -> DATA reads 0x002A, busy=0.
REQ-031 Bench SHALL cover: DATA=0x0005, CTRL=0x1 -> o_ir_writedata=0x0005, rwn=0, held stable until done.
REQ-032 Bench SHALL cover: CHADDR=4 with NUM_CHANNELS=4, then start -> no trigger, CTRL reads 0x0200.
REQ-033 Bench SHALL cover: no i_ir_done after start -> busy drops after TIMEOUT_CYCLES, CTRL reads 0x0600; write 0x0600 -> CTRL reads 0x0000.
REQ-034 Bench SHALL cover: DATA write while busy -> o_ir_writedata unchanged, error=1.
REQ-035 Bench SHALL cover: reset asserted in WAIT_DONE -> all outputs 0, later i_ir_done ignored.
